// File: rtl/bcd2binary_seq.sv
// Purpose : multi-cycle BCD-to-binary converter (reverse double dabble, one shift per clock).
// Latency : BW shift cycles after the accepting edge; done pulses for one cycle, so back-to-back throughput is BW+1.
// Backpressure: start is sampled only while idle; starts during a conversion are dropped, never queued.
//
// Optional build macro: BCD2BIN_RANGE_CHECK_EN
//   defined   - a start with any digit above 9 is rejected in one cycle with done=1, err=1 and bin untouched.
//   undefined - no digit check; err is tied low and every start is converted through the normal path.
module bcd2binary_seq #(
    parameter int DIGITS = 3,
    // Must satisfy 2^BW > 10^DIGITS - 1; it is also the number of shift steps.
    parameter int BW     = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic [BW-1:0]         bin,
    output logic                  err
);

    // Shift register holds the BCD digits in the upper field and the binary
    // result accumulating in the lower field.
    localparam int BCDW  = 4 * DIGITS;
    localparam int SRW   = BCDW + BW;
    localparam int CNT_W = $clog2(BW + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BW - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    logic [SRW-1:0]     sr;
    logic [CNT_W-1:0]   cnt;
    logic [SRW-1:0]     shifted;
    logic [SRW-1:0]     corrected;

    // One reverse double dabble step: shift right, then pull every BCD nibble
    // that reached 8 or more back down by 3 (no borrow across nibbles).
    always_comb begin
        shifted   = sr >> 1;
        corrected = shifted;
        for (int i = 0; i < DIGITS; i++) begin
            if (shifted[BW + 4*i + 3 -: 4] >= 4'd8) begin
                corrected[BW + 4*i + 3 -: 4] = shifted[BW + 4*i + 3 -: 4] - 4'd3;
            end
        end
    end

`ifdef BCD2BIN_RANGE_CHECK_EN
    logic digit_bad;

    // Flags an input word carrying any digit outside 0..9.
    always_comb begin
        digit_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i + 3 -: 4] > 4'd9) begin
                digit_bad = 1'b1;
            end
        end
    end

    // Control FSM and datapath; a bad input is answered in one cycle from IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bin   <= '0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (digit_bad) begin
                            // Reject: stay idle, keep the previous result.
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            sr    <= {bcd, {BW{1'b0}}};
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    sr  <= corrected;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        bin   <= corrected[BW-1:0];
                        err   <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
`else
    // Without the digit check there is no error condition to report.
    assign err = 1'b0;

    // Control FSM and datapath: load on start, then BW correction steps.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bin   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr    <= {bcd, {BW{1'b0}}};
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr  <= corrected;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        bin   <= corrected[BW-1:0];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_bcd2binary_seq.sv
// Purpose : self-checking bench for bcd2binary_seq with a result scoreboard.
// Latency : expects done BW+1 sampled cycles after start is presented.
// Backpressure: exercises ignored starts, held start and reset abort.
module tb_bcd2binary_seq;

    localparam int DIGITS = 3;
    localparam int BW     = 10;

    logic                clk;
    logic                rst;
    logic                start;
    logic [4*DIGITS-1:0] bcd;
    logic                busy;
    logic                done;
    logic [BW-1:0]       bin;
    logic                err;

    int checks = 0;
    int errors = 0;

    // Expected {err, bin} per done pulse, pushed when stimulus is driven.
    logic [BW:0] sb[$];

    bcd2binary_seq #(.DIGITS(DIGITS), .BW(BW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bcd   (bcd),
        .busy  (busy),
        .done  (done),
        .bin   (bin),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] model(input logic [11:0] b);
        int v;
        v = int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
        return BW'(v);
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        logic [BW:0] e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(bin), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("bin", 32'(bin), 32'(e[BW-1:0]));
                chk("err", 32'(err), 32'(e[BW]));
            end
        end
    end

    // Present one start pulse and follow the conversion to its done cycle.
    task automatic run_one(input logic [11:0] b);
        int n;
        bcd   = b;
        start = 1'b1;
        sb.push_back({1'b0, model(b)});
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
            if (done !== 1'b1) chk("busy_conv", 32'(busy), 32'd1);
        end while (done !== 1'b1 && n < 40);
        chk("latency", n, BW + 1);
    endtask

    initial begin
        int nd;
        rst   = 1'b1;
        start = 1'b0;
        bcd   = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bin",  32'(bin),  32'd0);
        chk("rst_err",  32'(err),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic conversions and hold of the result.
        run_one(12'h000);
        run_one(12'h255);
        run_one(12'h999);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_bin",  32'(bin),  32'd999);
            chk("hold_busy", 32'(busy), 32'd0);
            chk("hold_done", 32'(done), 32'd0);
        end

        // Start held high for 25 cycles: three conversions, 11-cycle spacing.
        bcd   = 12'h128;
        start = 1'b1;
        repeat (3) sb.push_back({1'b0, 10'd128});
        nd = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 25) start = 1'b0;
            if (done === 1'b1) begin
                nd++;
                chk("rep_spacing", k, (BW + 1) * nd);
            end else if (k <= 33) begin
                chk("rep_busy", 32'(busy), 32'd1);
            end
        end
        chk("rep_count", nd, 3);

        // A start during a conversion is ignored and bcd changes are not seen.
        bcd   = 12'h042;
        start = 1'b1;
        sb.push_back({1'b0, 10'd42});
        nd = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 3) begin
                bcd   = 12'h777;
                start = 1'b1;
            end
            if (k == 4) start = 1'b0;
            if (k == 5) chk("ign_busy", 32'(busy), 32'd1);
            if (done === 1'b1) begin
                nd++;
                chk("ign_done_cyc", k, BW + 1);
            end
        end
        chk("ign_count", nd, 1);

        // Reset in the middle of a conversion aborts without a done pulse.
        bcd   = 12'h500;
        start = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            chk("abort_nodone", 32'(done), 32'd0);
            if (k == 5) rst = 1'b1;
            if (k == 6) begin
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_bin",  32'(bin),  32'd0);
                rst = 1'b0;
            end
        end
        run_one(12'h500);

`ifdef BCD2BIN_RANGE_CHECK_EN
        // A bad digit is rejected in one cycle and leaves bin untouched.
        run_one(12'h042);
        bcd   = 12'h0A3;
        start = 1'b1;
        sb.push_back({1'b1, 10'd42});
        @(negedge clk);
        start = 1'b0;
        chk("rc_done", 32'(done), 32'd1);
        chk("rc_err",  32'(err),  32'd1);
        chk("rc_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rc_idle_busy", 32'(busy), 32'd0);
            chk("rc_hold_bin",  32'(bin),  32'd42);
        end
        run_one(12'h013);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd2binary_seq.md
Name: bcd2binary_seq

Overview:
- Multi-cycle BCD-to-binary converter; the inverse of the team's combinational binary-to-BCD block.
- Converts a hundreds/tens/ones digit triple into a plain binary value using reverse double dabble: shift right one bit per clock, then subtract 3 from every nibble that is 8 or more.
- Sits between the vending machine keypad/price-entry digit registers and the binary credit/price arithmetic.
- Uses a start/busy/done handshake, so the FSM datapath stays fully registered.

Parameters:
- DIGITS, 3, number of BCD digits converted; digit 0 is the ones digit.
- BW, 10, binary result width; must satisfy 2^BW > 10^DIGITS - 1 (10 covers 999). It also sets the shift count.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request conversion; sampled only in IDLE
- bcd  input  4*DIGITS  packed digits; [3:0] ones, [7:4] tens, [11:8] hundreds
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when bin (and err) are updated
- bin  output  BW  binary result; held until the next successful conversion
- err  output  1  digit-range error flag; see Optional Feature

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, err=0, bin=0, internal shift register and counter cleared.
- Internal register: shift register of 4*DIGITS+BW bits (BCD field above, binary field below), plus a counter of ceil(log2(BW+1)) bits.
- IDLE:
  - busy=0.
  - start=1 at edge E0: BCD field <= bcd, binary field <= 0, cnt <= 0, state -> SHIFT, busy=1 from E0 onward.
  - start=0: remain in IDLE.
- SHIFT, one operation per edge:
  - Logical right shift of the whole register by 1.
  - Then, for each BCD nibble of the shifted value: if nibble >= 8, subtract 3 (4-bit arithmetic, no borrow into neighbours).
  - cnt increments each edge.
  - On the edge where cnt == BW-1: bin <= binary field of the corrected shifted value, done <= 1, busy <= 0, state -> IDLE.
- Latency:
  - Exactly BW shift edges (E1..E10 for BW=10).
  - done is high during the single cycle following edge E0+BW; busy falls at the same edge.
  - A new start can be accepted in that same done cycle (back-to-back throughput BW+1 cycles).
- Boundary conditions:
  - start while busy: ignored; no queuing.
  - start held high continuously: conversions repeat every BW+1 cycles; bcd is re-sampled at each accept.
  - bcd changes during SHIFT: no effect; the value was captured at E0.
  - rst during SHIFT: abort immediately to reset values; no done pulse.
  - Result never exceeds 10^DIGITS - 1; no overflow is possible given the BW constraint.
- done is a registered pulse, never combinational from start.

Optional Feature:
- Macro: BCD2BIN_RANGE_CHECK_EN
- Defined:
  - At the accepting edge E0, if any digit of bcd > 9: state stays IDLE, busy stays 0, bin unchanged.
  - At E0+1, done=1 and err=1 for one cycle.
  - A valid conversion sets err=0 at its done edge; err holds its value until the next done.
- Not defined:
  - No digit check; err is tied to 0.
  - Digits > 9 are converted through the normal path with normal timing; the bin value is unspecified.

Test Plan:
- Reset, then bcd=0/0/0, start pulse at E0 -> busy=1 for 10 cycles, done pulse after E0+10, bin=0, err=0.
- bcd=2/5/5 -> bin=255 (0x0FF) at done; then bcd=9/9/9 -> bin=999 (0x3E7); bin holds between conversions.
- bcd=1/2/8, start held high for 25 cycles -> done pulses at 11-cycle spacing, bin=128 each time, busy never glitches.
- Start accepted with bcd=0/4/2; pulse start again at E0+3 with bcd=7/7/7 -> second start ignored, single done, bin=42.
- Start bcd=5/0/0, assert rst at E0+5 -> busy=0, bin=0 next cycle, no done pulse; a fresh start with 5/0/0 then gives bin=500.
- With BCD2BIN_RANGE_CHECK_EN: prior bin=42, bcd=0/A/3 start -> done+err at E0+1, busy never high, bin stays 42; next valid 0/1/3 -> bin=13, err=0.
